// File: rtl/controlador_texto.sv
// rtl/controlador_texto.sv - 11-character text line with shadow buffer committed on vsync falling edge
module controlador_texto #(
   parameter int N_CHARS = 11,
   parameter int CW      = 8,
   parameter int IW      = 4
) (
   input  logic          clock_25,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [CW-1:0] cmd_data,
   input  logic          vsync,
   output logic [CW-1:0] char [0:N_CHARS-1],
   output logic [IW-1:0] cursor,
   output logic          line_full,
   output logic          dirty
);

   typedef enum logic [1:0] {IDLE, CLEAR, COMMIT} state_t;

   localparam logic [1:0]    OP_WRITE = 2'b00;
   localparam logic [1:0]    OP_BKSP  = 2'b01;
   localparam logic [1:0]    OP_CLEAR = 2'b10;
   localparam logic [1:0]    OP_SETC  = 2'b11;
   localparam logic [IW-1:0] FULL_POS = IW'(N_CHARS);
   localparam logic [IW-1:0] LAST_POS = IW'(N_CHARS - 1);

   state_t          state, state_next;
   logic [CW-1:0]   shadow [0:N_CHARS-1];
   logic [IW-1:0]   clr_idx;
   logic            pending;
   logic            vsync_q;
   logic            frame_edge;
   logic            accept;
   logic            do_write, do_bksp, do_clear, do_setc;

   assign frame_edge = vsync_q & ~vsync;
   assign accept     = cmd_valid && (state == IDLE);
   assign do_write   = accept && (cmd_op == OP_WRITE) && (cursor < FULL_POS);
   assign do_bksp    = accept && (cmd_op == OP_BKSP) && (cursor != '0);
   assign do_clear   = accept && (cmd_op == OP_CLEAR);
   assign do_setc    = accept && (cmd_op == OP_SETC);
   assign line_full  = (cursor == FULL_POS);

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (do_clear)
               state_next = CLEAR;
            else if (frame_edge && (dirty || do_write || do_bksp))
               state_next = COMMIT;
         end
         CLEAR: begin
            // A frame edge on the final clear cycle still schedules the commit.
            if (clr_idx == LAST_POS)
               state_next = (pending || frame_edge) ? COMMIT : IDLE;
         end
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_25) begin
      if (reset) begin
         state   <= IDLE;
         cursor  <= '0;
         dirty   <= 1'b0;
         pending <= 1'b0;
         clr_idx <= '0;
         vsync_q <= 1'b1;
         for (int i = 0; i < N_CHARS; i++) begin
            shadow[i] <= '0;
            char[i]   <= '0;
         end
      end else begin
         state   <= state_next;
         vsync_q <= vsync;
         case (state)
            IDLE: begin
               if (do_write) begin
                  shadow[cursor] <= cmd_data;
                  cursor         <= cursor + 1'b1;
                  dirty          <= 1'b1;
               end
               if (do_bksp) begin
                  shadow[cursor - 1'b1] <= '0;
                  cursor                <= cursor - 1'b1;
                  dirty                 <= 1'b1;
               end
               if (do_clear) begin
                  cursor  <= '0;
                  clr_idx <= '0;
                  pending <= frame_edge;
               end
               if (do_setc)
                  cursor <= (cmd_data > CW'(N_CHARS)) ? FULL_POS : cmd_data[IW-1:0];
            end
            CLEAR: begin
               shadow[clr_idx] <= '0;
               clr_idx         <= clr_idx + 1'b1;
               if (frame_edge)
                  pending <= 1'b1;
               if (clr_idx == LAST_POS)
                  dirty <= 1'b1;
            end
            COMMIT: begin
               for (int i = 0; i < N_CHARS; i++)
                  char[i] <= shadow[i];
               dirty   <= 1'b0;
               pending <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_controlador_texto.sv
// tb/tb_controlador_texto.sv - scoreboard bench for controlador_texto with randomized commands
module tb_controlador_texto;
   localparam int N = 11;

   typedef struct packed {
      logic [3:0]     cur;
      logic           full;
      logic           dirty;
      logic           ready;
      logic [N*8-1:0] disp;
   } exp_t;

   logic       clock_25 = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_data = 8'd0;
   logic       vsync = 1'b1;
   logic       cmd_ready, line_full, dirty;
   logic [3:0] cursor;
   logic [7:0] disp_o [0:N-1];

   controlador_texto #(.N_CHARS(N), .CW(8), .IW(4)) dut (
      .clock_25 (clock_25),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_data (cmd_data),
      .vsync    (vsync),
      .char     (disp_o),
      .cursor   (cursor),
      .line_full(line_full),
      .dirty    (dirty)
   );

   always #5 clock_25 = ~clock_25;

   int checks = 0;
   int failures = 0;

   // Reference: line contents as arrays, clear as a busy countdown, commit as a one-shot flag.
   int         m_cur;
   bit         m_dirty;
   int         m_clear_left;
   bit         m_commit_now;
   bit         m_commit_after;
   bit         m_vs_prev;
   logic [7:0] m_shadow [N];
   logic [7:0] m_disp [N];
   exp_t       exp_q [$];
   exp_t       mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.cur   = 4'(m_cur);
      e.full  = (m_cur == N);
      e.dirty = m_dirty;
      e.ready = (m_clear_left == 0) && !m_commit_now;
      for (int i = 0; i < N; i++)
         e.disp[i*8 +: 8] = m_disp[i];
      return e;
   endfunction

   task automatic model_reset();
      m_cur = 0; m_dirty = 0; m_clear_left = 0;
      m_commit_now = 0; m_commit_after = 0; m_vs_prev = 1;
      for (int i = 0; i < N; i++) begin
         m_shadow[i] = 8'd0;
         m_disp[i]   = 8'd0;
      end
   endtask

   task automatic model_cycle(input bit v, input logic [1:0] op, input logic [7:0] d, input bit vs);
      bit edge_now;
      edge_now  = m_vs_prev && !vs;
      m_vs_prev = vs;
      if (m_commit_now) begin
         for (int i = 0; i < N; i++) m_disp[i] = m_shadow[i];
         m_dirty = 0;
         m_commit_now = 0;
         m_commit_after = 0;
      end else if (m_clear_left > 0) begin
         if (edge_now) m_commit_after = 1;
         m_clear_left--;
         if (m_clear_left == 0) begin
            m_dirty = 1;
            if (m_commit_after) m_commit_now = 1;
         end
      end else begin
         if (v && op == 2'b10) begin
            m_cur = 0;
            for (int i = 0; i < N; i++) m_shadow[i] = 8'd0;
            m_clear_left = N;
            m_commit_after = edge_now;
         end else begin
            if (v && op == 2'b00 && m_cur < N) begin
               m_shadow[m_cur] = d;
               m_cur++;
               m_dirty = 1;
            end else if (v && op == 2'b01 && m_cur > 0) begin
               m_cur--;
               m_shadow[m_cur] = 8'd0;
               m_dirty = 1;
            end else if (v && op == 2'b11) begin
               m_cur = (d > N) ? N : int'(d);
            end
            if (edge_now && m_dirty) m_commit_now = 1;
         end
      end
   endtask

   task automatic step(input bit v, input logic [1:0] op, input logic [7:0] d, input bit vs);
      cmd_valid = v;
      cmd_op    = op;
      cmd_data  = d;
      vsync     = vs;
      model_cycle(v, op, d, vs);
      exp_q.push_back(snapshot());
      @(posedge clock_25);
      #2;
   endtask

   task automatic step_reset();
      reset     = 1'b1;
      cmd_valid = 1'b0;
      vsync     = 1'b1;
      model_reset();
      exp_q.push_back(snapshot());
      @(posedge clock_25);
      #2;
      reset = 1'b0;
   endtask

   task automatic idle(input int n, input bit vs);
      for (int k = 0; k < n; k++) step(1'b0, 2'b00, 8'd0, vs);
   endtask

   always @(posedge clock_25) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("cursor", 32'(cursor), 32'(mon_e.cur));
         chk("line_full", 32'(line_full), 32'(mon_e.full));
         chk("dirty", 32'(dirty), 32'(mon_e.dirty));
         chk("cmd_ready", 32'(cmd_ready), 32'(mon_e.ready));
         for (int i = 0; i < N; i++)
            chk($sformatf("char[%0d]", i), 32'(disp_o[i]), 32'(mon_e.disp[i*8 +: 8]));
      end
   end

   initial begin
      int low_cnt;
      int r;
      bit v;
      logic [1:0] op;
      logic [7:0] d;
      model_reset();
      @(posedge clock_25);
      #2;
      step_reset();
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_cursor", 32'(cursor), 0);

      step(1, 2'b00, 8'd65, 1);
      step(1, 2'b00, 8'd66, 1);
      step(1, 2'b00, 8'd67, 1);
      chk("abc_cursor", 32'(cursor), 3);
      chk("abc_dirty", 32'(dirty), 1);
      chk("abc_char0_precommit", 32'(disp_o[0]), 0);
      step(0, 2'b00, 8'd0, 0);
      step(0, 2'b00, 8'd0, 1);
      chk("abc_char0", 32'(disp_o[0]), 65);
      chk("abc_char1", 32'(disp_o[1]), 66);
      chk("abc_char2", 32'(disp_o[2]), 67);
      chk("abc_char3", 32'(disp_o[3]), 0);
      chk("abc_dirty_after", 32'(dirty), 0);

      step(1, 2'b11, 8'd0, 1);
      for (int i = 0; i < 12; i++) begin
         step(1, 2'b00, 8'(100 + i), 1);
         if (i == 10) begin
            chk("full_after_11", 32'(line_full), 1);
            chk("cursor_after_11", 32'(cursor), 11);
         end
      end
      chk("cursor_after_12", 32'(cursor), 11);
      step(0, 2'b00, 8'd0, 0);
      step(0, 2'b00, 8'd0, 1);
      chk("full_char10", 32'(disp_o[10]), 110);

      step(1, 2'b10, 8'd0, 1);
      idle(11, 1);
      chk("ready_after_clear", 32'(cmd_ready), 1);
      step(1, 2'b00, 8'd88, 1);
      step(1, 2'b00, 8'd89, 1);
      step(1, 2'b01, 8'd0, 1);
      step(1, 2'b01, 8'd0, 1);
      step(1, 2'b01, 8'd0, 1);
      chk("bksp_cursor", 32'(cursor), 0);
      step(1, 2'b11, 8'd20, 1);
      chk("setc_clamp", 32'(cursor), 11);

      step(1, 2'b11, 8'd0, 1);
      step(1, 2'b00, 8'd75, 1);
      step(0, 2'b00, 8'd0, 0);
      step(0, 2'b00, 8'd0, 1);
      chk("pre_clear_char0", 32'(disp_o[0]), 75);
      step(1, 2'b10, 8'd0, 1);
      low_cnt = (cmd_ready == 1'b0) ? 1 : 0;
      for (int k = 0; k < 16; k++) begin
         step(0, 2'b00, 8'd0, (k == 2) ? 1'b0 : 1'b1);
         if (cmd_ready == 1'b0) low_cnt++;
      end
      chk("clear_commit_busy", 32'(low_cnt), 12);
      chk("clear_commit_char0", 32'(disp_o[0]), 0);
      chk("clear_commit_ready", 32'(cmd_ready), 1);

      step(1, 2'b00, 8'd90, 0);
      step(0, 2'b00, 8'd0, 1);
      chk("edge_write_char0", 32'(disp_o[0]), 90);

      step(1, 2'b00, 8'd81, 1);
      step(1, 2'b10, 8'd0, 1);
      idle(4, 1);
      step_reset();
      chk("rst_clear_ready", 32'(cmd_ready), 1);
      chk("rst_clear_cursor", 32'(cursor), 0);
      chk("rst_clear_char0", 32'(disp_o[0]), 0);
      chk("rst_clear_dirty", 32'(dirty), 0);
      step(1, 2'b00, 8'd82, 1);
      step(0, 2'b00, 8'd0, 0);
      step_reset();
      chk("rst_commit_ready", 32'(cmd_ready), 1);
      chk("rst_commit_char0", 32'(disp_o[0]), 0);
      chk("rst_commit_dirty", 32'(dirty), 0);
      chk("rst_commit_full", 32'(line_full), 0);

      for (int k = 0; k < 3000; k++) begin
         v = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 15);
         if (r < 9)       op = 2'b00;
         else if (r < 12) op = 2'b01;
         else if (r < 13) op = 2'b10;
         else             op = 2'b11;
         d = (op == 2'b11) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
         step(v, op, d, ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1);
         if (k == 1500) step_reset();
      end
      idle(3, 1);
      chk("queue_drained", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/controlador_texto.md
# controlador_texto

Text-line controller that owns the 11-character line shown by the VGA text path and sequences all updates to it. Accepts character commands (write, backspace, clear, set cursor) through a valid/ready port into a shadow buffer. Publishes the shadow to the displayed `char` array only at the start of the vertical sync pulse, so the text writer never sees a half-updated line. It sits between the input source (keypad/calculator logic) and `controlador_vga`, driving its `char` input.

## Interface
- `N_CHARS`, 11: characters per line; display array is `[0:N_CHARS-1]`.
- `CW`, 8: character code width; code 8'd0 is blank.
- `IW`, 4: cursor width, ≥ clog2(N_CHARS+1).

- `clock_25`  in  1  pixel clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  2  00 write, 01 backspace, 10 clear, 11 set cursor.
- `cmd_data`  in  CW  character code (write) or cursor index (set cursor).
- `vsync`  in  1  active-low vertical sync from the sincronizador.
- `char`  out  [0:CW-1] × [0:N_CHARS-1]  displayed line, registered.
- `cursor`  out  IW  next write position, 0..N_CHARS.
- `line_full`  out  1  `cursor == N_CHARS`.
- `dirty`  out  1  shadow differs from display (uncommitted change).

## Operation
- State: `shadow[0:N_CHARS-1]`, `cursor`, `dirty`, `pending`, `clr_idx`, `vsync_q`; FSM {IDLE, CLEAR, COMMIT}.
- Reset: shadow and `char` all 8'd0, `cursor`=0, `dirty`=0, `pending`=0, `vsync_q`=1, IDLE, `cmd_ready`=1, `line_full`=0. Reset at any point, including mid-CLEAR or in COMMIT, aborts the operation and restores these values.
- `cmd_ready` = 1 only in IDLE.
- Commands (IDLE, on accept):
  - write: if `cursor < N_CHARS`: `shadow[cursor]<=cmd_data`, `cursor+1`, `dirty<=1`. If full: accepted and dropped, no state change.
  - backspace: if `cursor > 0`: `cursor-1`, `shadow[cursor-1]<=0`, `dirty<=1`. At 0: no-op.
  - clear: `cursor<=0`, `clr_idx<=0`, go CLEAR.
  - set cursor: `cursor <= min(cmd_data, N_CHARS)`. `dirty` unchanged.
- CLEAR: writes `shadow[clr_idx]<=0` and increments `clr_idx`, one entry per cycle. After entry N_CHARS-1, sets `dirty<=1` and goes to IDLE, or to COMMIT if `pending`.
- Frame edge: `vsync_q<=vsync` every cycle. Edge = `vsync_q && !vsync`.
  - IDLE on edge: if `dirty`, or a dirty-setting command is accepted that same cycle, go COMMIT. That command is included in the commit.
  - CLEAR on edge: set `pending`.
  - COMMIT on edge: ignored.
  - Edge with nothing dirty: no action.
- COMMIT (exactly one cycle): `char <= shadow` for all entries, `dirty<=0`, `pending<=0`, then go IDLE.
- `char` changes only in COMMIT and on reset.

## Timing
- Command accepted at edge k: shadow and `cursor` valid after edge k+1.
- Vsync falling edge sampled at cycle e (vsync=0, vsync_q=1): COMMIT during e+1; new `char` visible from e+2. `cmd_ready`=0 during e+1.
- Clear accepted at cycle c: `cmd_ready`=0 for cycles c+1..c+N_CHARS (11 cycles), and 1 again at c+N_CHARS+1 unless a COMMIT is pending. A pending COMMIT occupies cycle c+N_CHARS+1, and `cmd_ready` returns at c+N_CHARS+2.
- `line_full` and `cursor` are registered and track the state with no extra latency.
- Throughput: one command per cycle in IDLE.

## Test plan
- Reset, then write 'A'(65), 'B'(66), 'C'(67) with vsync=1: `cursor`=3, `dirty`=1, `char` all 0. Then drive a vsync 1→0: two cycles later `char[0:2]`={65,66,67}, others 0, `dirty`=0.
- Write 12 characters: `line_full`=1 after the 11th and `cursor`=11. The 12th is accepted and dropped; after commit, `char[10]` holds the 11th code.
- Write 'X','Y', then backspace ×3: `cursor`=0, shadow all 0, third backspace is a no-op. Set cursor with `cmd_data`=20: `cursor`=11.
- Issue clear, then a vsync falling edge 3 cycles later: `cmd_ready` low for 11 cycles, COMMIT follows with `char` all 0, then `cmd_ready`=1.
- Write accepted in the same cycle as the vsync edge: that character appears in `char` at e+2.
- Assert reset during CLEAR and during COMMIT: the next cycle shows all outputs at their reset values, IDLE, `cmd_ready`=1.
